// File: rtl/nibble_tx_pkg.sv
// Shared constants and helpers for the nibble serial transmitter.
// Holds the FSM state encodings and the frame bit-count constants.
package nibble_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StStart  = 3'd1;
    localparam state_t StData   = 3'd2;
    localparam state_t StParity = 3'd3;
    localparam state_t StStop   = 3'd4;

    localparam int unsigned DataBits      = 4;
    // Start bit + data bits + stop bit; parity adds one more when enabled.
    localparam int unsigned FrameBitsBase = DataBits + 2;

    function automatic logic nibble_parity(input logic [3:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/nibble_tx_baud.sv
// Bit-period timer: counts clock cycles inside one serial bit and emits a
// single-cycle tick on the last cycle of each bit. Restart realigns the count.
module nibble_tx_baud #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LastCnt = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick = enable && !restart && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nibble_tx.sv
// Framed parallel-in/serial-out transmitter for 4-bit nibbles:
// start bit, data LSB first, optional parity, one stop bit.
module nibble_tx
    import nibble_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_o,
    output logic       busy,
    output logic       done
);

    localparam logic       ParityOn  = (PARITY_EN != 0);
    localparam logic       ParityOdd = (PARITY_ODD != 0);
    localparam logic [1:0] LastIdx   = 2'(DataBits - 1);

    state_t     state_q, state_d;
    logic [3:0] shreg_q, shreg_d;
    logic [1:0] idx_q, idx_d;
    logic       parity_q, parity_d;
    logic       done_q, done_d;
    logic       tx_q, tx_d;
    logic       accept;
    logic       tick;

    assign in_ready = (state_q == StIdle);
    assign busy     = ~in_ready;
    assign accept   = in_valid && in_ready;
    assign done     = done_q;
    assign tx_o     = tx_q;

    nibble_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(accept),
        .enable (busy),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d  = StStart;
                    shreg_d  = in_data;
                    idx_d    = '0;
                    parity_d = nibble_parity(in_data, ParityOdd);
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shreg_d = {1'b0, shreg_q[3:1]};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == LastIdx) begin
                        state_d = ParityOn ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level is registered from next-state so tx_o never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            done_q   <= done_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: doc/nibble_tx.md
NIBBLE_TX -- requirements
Module: nibble_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter PARITY_EN, default 1: 1 = parity bit inserted after data; 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 in_data  input  4  parallel nibble to transmit.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block will accept a nibble this cycle.
REQ-009 tx_o  output  1  serial line; idle level 1.
REQ-010 busy  output  1  a frame is in progress.
REQ-011 done  output  1  one-cycle pulse at frame end.

Function
REQ-012 The block SHALL be a framed parallel-in/serial-out transmitter: start bit (0), in_data[0..3] LSB first, optional parity, one stop bit (1).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-014 in_ready SHALL equal 1 exactly when state is IDLE; busy SHALL equal the inverse of in_ready.
REQ-015 A transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_data is captured into an internal 4-bit shift register on that edge.
REQ-016 In the cycle after the transfer edge, tx_o SHALL be 0 (START), i.e. latency from acceptance to line activity is 1 cycle.
REQ-017 Each bit SHALL be driven on tx_o for exactly CLKS_PER_BIT consecutive cycles, timed by a bit-cycle counter that reloads at each bit boundary.
REQ-018 In DATA, the shift register SHALL shift right one position per bit boundary; tx_o = shift register bit 0; a 2-bit index counts 0..3, leaving DATA after index 3.
REQ-019 The parity bit SHALL be XOR of the captured nibble, inverted when PARITY_ODD=1.
REQ-020 Frame length SHALL be (6 + PARITY_EN) * CLKS_PER_BIT cycles from first START cycle to last STOP cycle inclusive.
REQ-021 done SHALL pulse 1 in the cycle after the last STOP cycle, coinciding with return to IDLE and in_ready=1.
REQ-022 A new nibble SHALL be acceptable in the same cycle done is high, giving back-to-back frames with no idle bit between stop and next start.
REQ-023 in_valid and in_data SHALL be ignored while busy=1; captured data is not affected by input changes mid-frame.
REQ-024 tx_o SHALL be 1 in IDLE and STOP.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, tx_o=1, in_ready=1, busy=0, done=0, counters and shift register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done pulse; the line returns to 1 immediately.
REQ-027 After rst_n deasserts, the first transfer SHALL be accepted on the first rising edge with in_valid=1.

Structure
REQ-028 Shared package nibble_tx_pkg SHALL hold the FSM state enum and the frame-bit-count constant.
REQ-029 Bit timing SHALL be a sub-module nibble_tx_baud (counter with restart input, one-cycle bit-end tick output).

Verification
REQ-030 CLKS_PER_BIT=4, even parity, in_data=4'b1010 -> tx_o bits 0,0,1,0,1,0,1 each 4 cycles (28 cycles), then done=1 for one cycle.
REQ-031 Odd parity, in_data=4'b0111 -> parity bit 0; in_data=4'b0011 -> parity bit 1.
REQ-032 PARITY_EN=0, CLKS_PER_BIT=1, in_data=4'hF -> tx_o 0,1,1,1,1,1 over 6 cycles; done at cycle 7.
REQ-033 in_valid held high with 4'h5 then 4'hA -> two consecutive frames, no idle gap, exactly two done pulses.
REQ-034 rst_n pulsed low during DATA bit 2 -> tx_o=1 and in_ready=1 immediately, no done pulse; next nibble transmits correctly.
REQ-035 in_data changed every cycle while busy -> transmitted bits match the nibble captured at acceptance.
